// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared helpers for the radix-2 butterfly datapath
// Helpers work in HMAX-bit containers; callers pass the live component width h.
package fft_pkg;

  localparam int HMAX = 24;

  function automatic logic [HMAX-1:0] h_mask(input int h);
    return (HMAX'(1) << h) - HMAX'(1);
  endfunction

  function automatic logic signed [HMAX-1:0] h_sext(input logic [HMAX-1:0] f, input int h);
    logic [HMAX-1:0] m;
    m = h_mask(h);
    if (((f >> (h - 1)) & HMAX'(1)) != '0) return $signed(f | ~m);
    return $signed(f & m);
  endfunction

  function automatic logic signed [HMAX-1:0] cplx_unpack(input logic [2*HMAX-1:0] x,
                                                         input int h, input logic im);
    logic [2*HMAX-1:0] f;
    f = im ? (x >> h) : x;
    return h_sext(HMAX'(f), h);
  endfunction

  function automatic logic [2*HMAX-1:0] cplx_pack(input logic [HMAX-1:0] re,
                                                  input logic [HMAX-1:0] im, input int h);
    logic [2*HMAX-1:0] m;
    m = (2*HMAX)'(h_mask(h));
    return (((2*HMAX)'(im) & m) << h) | ((2*HMAX)'(re) & m);
  endfunction

  // The LUT encodes +1.0 as the otherwise-negative code 100..0.
  function automatic logic signed [HMAX:0] tw_decode(input logic [HMAX-1:0] f, input int h);
    logic [HMAX-1:0] fv;
    logic [HMAX-1:0] half;
    half = HMAX'(1) << (h - 1);
    fv   = f & h_mask(h);
    if (fv == half) return $signed({1'b0, half});
    return (HMAX+1)'(h_sext(fv, h));
  endfunction

  // Result: clip flag at bit h, clipped value in bits [h-1:0].
  function automatic logic [HMAX:0] sat_h(input logic signed [HMAX+2:0] v, input int h);
    logic signed [HMAX+2:0] lim;
    logic signed [HMAX+2:0] q;
    logic                   clip;
    lim  = $signed((HMAX+3)'(1) << (h - 1));
    clip = 1'b1;
    if (v >= lim) begin
      q = lim - $signed((HMAX+3)'(1));
    end else if (v < -lim) begin
      q = -lim;
    end else begin
      q    = v;
      clip = 1'b0;
    end
    return ((HMAX+1)'(clip) << h) | ((HMAX+1)'(q) & (HMAX+1)'(h_mask(h)));
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - two-stage complex multiply B * W' feeding the butterfly
// Stage 1 registers B and the decoded twiddle; stage 2 registers the scaled product.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int H    = 4,
  parameter int CONJ = 1
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic [2*H-1:0]      i_b,
  input  logic [2*H-1:0]      i_tw,
  output logic signed [H+2:0] o_pr,
  output logic signed [H+2:0] o_pi
);

  localparam int PW = 2 * H + 2;

  logic signed [H:0]    w_wr;
  logic signed [H:0]    w_wi;
  logic signed [H-1:0]  r_br;
  logic signed [H-1:0]  r_bi;
  logic signed [H:0]    r_wr;
  logic signed [H:0]    r_wi;
  logic signed [PW-1:0] w_pr_full;
  logic signed [PW-1:0] w_pi_full;

  always_comb begin
    w_wr = (H+1)'(tw_decode(HMAX'(i_tw[H-1:0]), H));
    w_wi = (H+1)'(tw_decode(HMAX'(i_tw[2*H-1:H]), H));
    if (CONJ != 0) w_wi = -w_wi;
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_br <= H'(cplx_unpack((2*HMAX)'(i_b), H, 1'b0));
      r_bi <= H'(cplx_unpack((2*HMAX)'(i_b), H, 1'b1));
      r_wr <= w_wr;
      r_wi <= w_wi;
    end
  end

  always_comb begin
    w_pr_full = PW'(r_br) * PW'(r_wr) - PW'(r_bi) * PW'(r_wi);
    w_pi_full = PW'(r_br) * PW'(r_wi) + PW'(r_bi) * PW'(r_wr);
  end

  // Drop the twiddle's 2^(H-1) scale with a flooring shift.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_pr <= (H+3)'(w_pr_full >>> (H - 1));
      o_pi <= (H+3)'(w_pi_full >>> (H - 1));
    end
  end

endmodule

// File: rtl/fft_butterfly_pipe.sv
// rtl/fft_butterfly_pipe.sv - 3-stage radix-2 DIT butterfly X = A + W'B, Y = A - W'B
// Whole pipe stalls together on downstream backpressure; bubbles travel with the data.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter  int SAMPLES = 8,
  parameter  int WIDTH   = 8,
  parameter  int CONJ    = 1,
  parameter  int SCALE   = 1,
  localparam int H       = WIDTH / 2,
  localparam int TW      = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_tw,
  input  logic [TW-1:0]    in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [TW-1:0]    out_tag,
  output logic             out_sat
);

  logic                w_en;
  logic                r_v1;
  logic                r_v2;
  logic [WIDTH-1:0]    r_a1;
  logic [WIDTH-1:0]    r_a2;
  logic [TW-1:0]       r_tag1;
  logic [TW-1:0]       r_tag2;
  logic signed [H+2:0] w_pr;
  logic signed [H+2:0] w_pi;
  logic signed [H+2:0] w_ar;
  logic signed [H+2:0] w_ai;
  logic signed [H+2:0] w_sxr;
  logic signed [H+2:0] w_sxi;
  logic signed [H+2:0] w_syr;
  logic signed [H+2:0] w_syi;
  logic [H-1:0]        w_xr;
  logic [H-1:0]        w_xi;
  logic [H-1:0]        w_yr;
  logic [H-1:0]        w_yi;
  logic                w_cxr;
  logic                w_cxi;
  logic                w_cyr;
  logic                w_cyi;
  logic                w_clip;
  logic [WIDTH-1:0]    w_x;
  logic [WIDTH-1:0]    w_y;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  fft_cmul #(
    .H    (H),
    .CONJ (CONJ)
  ) u_cmul (
    .clk  (clk),
    .i_en (w_en),
    .i_b  (in_b),
    .i_tw (in_tw),
    .o_pr (w_pr),
    .o_pi (w_pi)
  );

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_a1   <= in_a;
      r_tag1 <= in_tag;
      r_a2   <= r_a1;
      r_tag2 <= r_tag1;
    end
  end

  always_comb begin
    w_ar  = (H+3)'(cplx_unpack((2*HMAX)'(r_a2), H, 1'b0));
    w_ai  = (H+3)'(cplx_unpack((2*HMAX)'(r_a2), H, 1'b1));
    w_sxr = w_ar + w_pr;
    w_sxi = w_ai + w_pi;
    w_syr = w_ar - w_pr;
    w_syi = w_ai - w_pi;
    if (SCALE != 0) begin
      w_sxr = w_sxr >>> 1;
      w_sxi = w_sxi >>> 1;
      w_syr = w_syr >>> 1;
      w_syi = w_syi >>> 1;
    end
    {w_cxr, w_xr} = (H+1)'(sat_h((HMAX+3)'(w_sxr), H));
    {w_cxi, w_xi} = (H+1)'(sat_h((HMAX+3)'(w_sxi), H));
    {w_cyr, w_yr} = (H+1)'(sat_h((HMAX+3)'(w_syr), H));
    {w_cyi, w_yi} = (H+1)'(sat_h((HMAX+3)'(w_syi), H));
    w_clip = w_cxr | w_cxi | w_cyr | w_cyi;
    w_x    = WIDTH'(cplx_pack(HMAX'(w_xr), HMAX'(w_xi), H));
    w_y    = WIDTH'(cplx_pack(HMAX'(w_yr), HMAX'(w_yi), H));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
    end else if (w_en) begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      if (r_v2) begin
        out_x   <= w_x;
        out_y   <= w_y;
        out_tag <= r_tag2;
        out_sat <= out_sat | w_clip;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// tb/tb_fft_butterfly_pipe.sv - scoreboard bench for fft_butterfly_pipe (SCALE=1 and SCALE=0)
module tb_fft_butterfly_pipe;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W-1:0]  in_tw;
  logic [TW-1:0] in_tag;

  logic          in_ready, out_valid, out_sat;
  logic [W-1:0]  out_x, out_y;
  logic [TW-1:0] out_tag;
  logic          in_ready0, out_valid0, out_sat0;
  logic [W-1:0]  out_x0, out_y0;
  logic [TW-1:0] out_tag0;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.SAMPLES(8), .WIDTH(W), .CONJ(1), .SCALE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  fft_butterfly_pipe #(.SAMPLES(8), .WIDTH(W), .CONJ(1), .SCALE(0)) dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_x(out_x0), .out_y(out_y0),
    .out_tag(out_tag0), .out_sat(out_sat0)
  );

  typedef struct {
    logic [W-1:0]  x1, y1, x0, y0;
    logic [TW-1:0] tag;
    bit            c1, c0;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   exp_sat1 = 0;
  bit   exp_sat0 = 0;
  logic [W-1:0] last_x, last_y, last_x0, last_y0;
  exp_t me;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int f);
    return (f >= (1 << (H - 1))) ? f - (1 << H) : f;
  endfunction

  function automatic int dec(input int f, input bit is_sin);
    int half;
    int v;
    half = 1 << (H - 1);
    v = (f == half) ? half : sx(f);
    if (is_sin) v = -v;
    return v;
  endfunction

  // Returns {clip, y_im, y_re, x_im, x_re}.
  function automatic logic [16:0] model(input logic [7:0] a, b, tw, input bit scale);
    int ar, ai, br, bi, wr, wi, pr, pi, v;
    int s [4];
    logic [3:0] q [4];
    bit clip;
    ar = sx(int'(a[3:0]));  ai = sx(int'(a[7:4]));
    br = sx(int'(b[3:0]));  bi = sx(int'(b[7:4]));
    wr = dec(int'(tw[3:0]), 1'b0);
    wi = dec(int'(tw[7:4]), 1'b1);
    pr = (br * wr - bi * wi) >>> (H - 1);
    pi = (br * wi + bi * wr) >>> (H - 1);
    s[0] = ar + pr;  s[1] = ai + pi;
    s[2] = ar - pr;  s[3] = ai - pi;
    clip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = scale ? (s[k] >>> 1) : s[k];
      if (v > 7) begin v = 7; clip = 1'b1; end
      else if (v < -8) begin v = -8; clip = 1'b1; end
      q[k] = v[3:0];
    end
    return {clip, q[3], q[2], q[1], q[0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 1, 0);
      end else begin
        me = sb.pop_front();
        exp_sat1 |= me.c1;
        exp_sat0 |= me.c0;
        check_eq("x",      out_x,      me.x1);
        check_eq("y",      out_y,      me.y1);
        check_eq("tag",    out_tag,    me.tag);
        check_eq("sat",    out_sat,    exp_sat1);
        check_eq("valid0", out_valid0, 1);
        check_eq("x0",     out_x0,     me.x0);
        check_eq("y0",     out_y0,     me.y0);
        check_eq("tag0",   out_tag0,   me.tag);
        check_eq("sat0",   out_sat0,   exp_sat0);
        last_x  = out_x;  last_y  = out_y;
        last_x0 = out_x0; last_y0 = out_y0;
        pops++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] a, b, tw, input logic [TW-1:0] tag);
    exp_t e;
    logic [16:0] m1, m0;
    int n;
    m1 = model(a, b, tw, 1'b1);
    m0 = model(a, b, tw, 1'b0);
    e.x1 = m1[7:0]; e.y1 = m1[15:8]; e.c1 = m1[16];
    e.x0 = m0[7:0]; e.y0 = m0[15:8]; e.c0 = m0[16];
    e.tag = tag;
    in_a = a; in_b = b; in_tw = tw; in_tag = tag; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check_eq("send_timeout", 0, 1);
    end else begin
      check_eq("in_ready0", in_ready0, 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start, p0, nv;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tw = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_x",     out_x,     0);
    check_eq("rst_y",     out_y,     0);
    check_eq("rst_tag",   out_tag,   0);
    check_eq("rst_sat",   out_sat,   0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    send(8'h02, 8'h02, 8'h08, 3'd0);
    drain();
    check_eq("w1_x", last_x, 8'h02);
    check_eq("w1_y", last_y, 8'h00);
    check_eq("w1_sat", out_sat, 0);

    send(8'h00, 8'h02, 8'h80, 3'd1);
    drain();
    check_eq("wj_x", last_x, 8'hF0);
    check_eq("wj_y", last_y, 8'h10);

    send(8'h07, 8'h07, 8'h08, 3'd2);
    drain();
    check_eq("sat_x0",   last_x0,  8'h07);
    check_eq("sat_y0",   last_y0,  8'h00);
    check_eq("sat_flag0", out_sat0, 1);
    check_eq("sat_flag1", out_sat,  0);

    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 8'($urandom), TW'(3 + i));
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_valid",    out_valid, 1);
    check_eq("bp_x_first",  out_x,   sb[0].x1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_x_hold",   out_x,   sb[0].x1);
    check_eq("bp_y_hold",   out_y,   sb[0].y1);
    check_eq("bp_tag_hold", out_tag, 3);
    check_eq("bp_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    drain();
    check_eq("bp_count", pops - p0, 3);

    pop_cyc.delete();
    start = cyc;
    for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 8'($urandom), TW'(i));
    drain();
    check_eq("st_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      check_eq("st_latency", pop_cyc[0] - start, 3);
      check_eq("st_span", pop_cyc[7] - pop_cyc[0], 7);
    end
    check_eq("sat0_sticky", out_sat0, 1);

    send(8'h11, 8'h22, 8'h08, 3'd6);
    send(8'h33, 8'h44, 8'h08, 3'd7);
    reset = 1'b1;
    #1;
    check_eq("mr_valid", out_valid,  0);
    check_eq("mr_valid0", out_valid0, 0);
    check_eq("mr_sat0",  out_sat0,   0);
    check_eq("mr_x",     out_x,      0);
    sb.delete();
    exp_sat1 = 0;
    exp_sat0 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || out_valid0) nv++;
    end
    check_eq("mr_no_out", nv, 0);
    @(posedge clk);
    #1;

    p0 = pops;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 8'($urandom), TW'(i));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("rand_count", pops - p0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
